// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Latency: start sampled at E0 gives hi/lo and a one-cycle done pulse after E0+WIDTH+1.
// Backpressure: busy stays high while an operation is in flight; start and MT writes are ignored then.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, op         request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled only in IDLE
//   src1, src2        multiplicand/dividend, multiplier/divisor
//   flush             cancel any in-flight operation
//   hi_we, lo_we      MTHI/MTLO write enables, with wdata as the write value
//   busy, done        in-flight flag, completion pulse
//   hi, lo            HI (product upper / remainder), LO (product lower / quotient)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W    = (2 * WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    // Multiply: a_reg = |multiplicand|. Divide: a_reg = raw dividend, kept for the divide-by-zero HI.
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_lo;     // negate product (mult) or quotient (div)
    logic               neg_hi;     // remainder takes the dividend's sign
    logic               div_zero;

    // ---------------- operand preparation ----------------
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    // op[0] set means unsigned; abs of the most negative value wraps to the same bit pattern,
    // which is exactly its magnitude when read as unsigned.
    assign s1_neg = ~op[0] & src1[WIDTH-1];
    assign s2_neg = ~op[0] & src2[WIDTH-1];
    assign abs1   = s1_neg ? (~src1 + ONE_W) : src1;
    assign abs2   = s2_neg ? (~src2 + ONE_W) : src2;

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Shift-add: add the multiplicand when the current multiplier LSB is set, then shift right
    // keeping the carry as the new top bit.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift one dividend bit into the remainder and try subtracting the divisor.
    // The shifted remainder needs WIDTH+1 bits; a borrow in the top bit means restore.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, b_reg};
    assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // ---------------- sign correction ----------------
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign prod_fin = neg_lo ? (~acc + ONE_2W) : acc;
    assign quot_fin = neg_lo ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
    assign rem_fin  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod_fin[2*WIDTH-1:WIDTH];
        res_lo = prod_fin[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_reg;
                res_lo = '1;
            end else begin
                res_hi = rem_fin;
                res_lo = quot_fin;
            end
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        // Start wins over a same-cycle MT write; that write is dropped.
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_lo   <= s1_neg ^ s2_neg;
                        neg_hi   <= op[1] & s1_neg;
                        div_zero <= op[1] & (src2 == '0);
                        b_reg    <= abs2;
                        if (op[1]) begin
                            a_reg <= src1;
                            acc   <= {{WIDTH{1'b0}}, abs1};
                        end else begin
                            a_reg <= abs1;
                            acc   <= {{WIDTH{1'b0}}, abs2};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic cases, latency, MT writes, flush and reset.
// Latency: checks done exactly 33 cycles after the start edge.
// Backpressure: exercises start/MT writes being ignored while busy.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src1  (src1),
        .src2  (src2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set afterwards are seen at the following edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done. lat counts edges after the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        int lat, bcnt;
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, lat, bcnt);
        n_checks++;
        if (lat !== 33) $display("FAIL mult_latency: got %0d required 33", lat);
        else n_pass++;
        n_checks++;
        if (bcnt !== 33) $display("FAIL mult_busy_cycles: got %0d required 33", bcnt);
        else n_pass++;
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
            $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffe", hi, lo);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mult_busy_at_done: busy=%b required 0", busy);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL mult_done_pulse: done=%b required 0 one cycle later", done);
        else n_pass++;
    endtask

    task automatic test_multu;
        int lat, bcnt;
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, bcnt);
        n_checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE)
            $display("FAIL multu_result: hi=%h lo=%h required 00000001/fffffffe", hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_div_signed;
        int lat, bcnt;
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
        n_checks++;
        if (lat !== 33) $display("FAIL div_latency: got %0d required 33", lat);
        else n_pass++;
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL div_neg7_by_2: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
        else n_pass++;
        tick();
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        n_checks++;
        if (hi !== 32'h0000_0000 || lo !== 32'h8000_0000)
            $display("FAIL div_min_by_neg1: hi=%h lo=%h required 00000000/80000000", hi, lo);
        else n_pass++;
        tick();
        // 100 / -7 = -14 rem 2 (remainder follows the dividend)
        do_op(2'b10, 32'd100, 32'hFFFF_FFF9, lat, bcnt);
        n_checks++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFF2)
            $display("FAIL div_100_by_neg7: hi=%h lo=%h required 00000002/fffffff2", hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        do_op(2'b11, 32'd7, 32'd0, lat, bcnt);
        n_checks++;
        if (lat !== 33) $display("FAIL divz_latency: got %0d required 33", lat);
        else n_pass++;
        n_checks++;
        if (hi !== 32'h0000_0007 || lo !== 32'hFFFF_FFFF)
            $display("FAIL divu_by_zero: hi=%h lo=%h required 00000007/ffffffff", hi, lo);
        else n_pass++;
        tick();
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
        n_checks++;
        if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF)
            $display("FAIL div_by_zero_signed: hi=%h lo=%h required fffffff9/ffffffff", hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_divu;
        int lat, bcnt;
        do_op(2'b11, 32'hFFFF_FFF9, 32'd16, lat, bcnt);
        n_checks++;
        if (hi !== 32'h0000_0009 || lo !== 32'h0FFF_FFFF)
            $display("FAIL divu_result: hi=%h lo=%h required 00000009/0fffffff", hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_mt_write;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        n_checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5)
            $display("FAIL mt_both: hi=%h lo=%h required a5a5a5a5/a5a5a5a5", hi, lo);
        else n_pass++;
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        tick();
        lo_we = 1'b0;
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        n_checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
            $display("FAIL mt_single: hi=%h lo=%h required 00001234/00005678", hi, lo);
        else n_pass++;
    endtask

    task automatic test_flush;
        int saw_done;
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'd3;
        src2  = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL flush_busy_before: busy=%b required 1", busy);
        else n_pass++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_busy_drop: busy=%b required 0", busy);
        else n_pass++;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done++;
            tick();
        end
        n_checks++;
        if (saw_done !== 0) $display("FAIL flush_no_done: done cycles=%0d required 0", saw_done);
        else n_pass++;
        n_checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
            $display("FAIL flush_hilo_kept: hi=%h lo=%h required 00001234/00005678", hi, lo);
        else n_pass++;
    endtask

    task automatic test_no_flush;
        int lat, bcnt;
        do_op(2'b01, 32'd3, 32'd5, lat, bcnt);
        n_checks++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'd15)
            $display("FAIL multu_3x5: lat=%0d hi=%h lo=%h required 33/00000000/0000000f", lat, hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_busy_ignore;
        int k;
        start = 1'b1;
        op    = 2'b11;
        src1  = 32'd100;
        src2  = 32'd7;
        tick();
        // Hold a new start and MT writes while busy; none may take effect.
        op    = 2'b01;
        src1  = 32'd9;
        src2  = 32'd9;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'd15)
            $display("FAIL busy_mt_ignored: hi=%h lo=%h required 00000000/0000000f", hi, lo);
        else n_pass++;
        k = 5;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k !== 33 || hi !== 32'd2 || lo !== 32'd14)
            $display("FAIL busy_start_ignored: lat=%0d hi=%h lo=%h required 33/00000002/0000000e", k, hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_priority;
        int lat;
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'd6;
        src2  = 32'd7;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_FFFF;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        n_checks++;
        if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b1)
            $display("FAIL start_over_mt: hi=%h lo=%h busy=%b required 00000002/0000000e/1", hi, lo, busy);
        else n_pass++;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'd42)
            $display("FAIL start_over_mt_result: hi=%h lo=%h required 00000000/0000002a", hi, lo);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        int saw_done;
        start = 1'b1;
        op    = 2'b10;
        src1  = 32'd100;
        src2  = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done++;
            tick();
        end
        n_checks++;
        if (saw_done !== 0) $display("FAIL reset_mid_quiet: busy/done cycles=%0d required 0", saw_done);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src1  = 32'h0;
        src2  = 32'h0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'h0;
        test_reset();
        test_mult();
        test_multu();
        test_div_signed();
        test_div_zero();
        test_divu();
        test_mt_write();
        test_flush();
        test_no_flush();
        test_busy_ignore();
        test_start_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Takes the same src1/src2 operands the ALU takes from ID/EX.
- Performs MIPS MULT/MULTU/DIV/DIVU over multiple cycles and holds the architectural HI/LO registers.
- Raises busy so the hazard unit stalls the pipeline until the result is ready; also services MTHI/MTLO writes and provides HI/LO reads for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src1  input  WIDTH  multiplicand / dividend
- src2  input  WIDTH  multiplier / divisor
- flush  input  1  cancel any in-flight operation
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight; hazard unit stalls on it
- done  output  1  one-cycle pulse; HI/LO updated this cycle
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal operand registers=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and flush=0 at edge E0: latch |src1| and |src2| (signed ops) or raw values (unsigned ops), record result signs and op; go to RUN with busy=1.
  - flush=1 takes priority over start.
  - start takes priority over hi_we/lo_we in the same cycle; the MT write is dropped.
  - Otherwise hi_we/lo_we load wdata into hi/lo at the edge; both may be set together.
- RUN:
  - One iteration per edge, E1..E32 (WIDTH edges).
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - Counter increments each iteration; after the WIDTH-th iteration go to FIN.
- FIN: at edge E33:
  - Apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo, set done=1 and busy=0, return to IDLE.
  - done is high for exactly the cycle after E33.
- Latency: start sampled at E0 gives hi/lo valid and done=1 after E33 (33 cycles). busy is high from after E0 through before E33.
- Signed abs of the most negative value is the same bit pattern, treated as unsigned; -2^31 / -1 gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU, src2=0): normal latency; sign correction bypassed; HI=src1 as originally presented, LO=all ones.
- start while busy: ignored. hi_we/lo_we while busy: ignored.
- flush in RUN or FIN: return to IDLE at the next edge, busy=0, done stays 0, hi/lo unchanged.
- Reset mid-operation: immediate return to reset values; no done pulse.
- hi/lo change only on reset, an MT write in IDLE, or completion in FIN.

Test Plan:
- MULT src1=0xFFFFFFFF, src2=0x00000002 → done after 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high for exactly 33 cycles.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV src1=0xFFFFFFF9 (-7), src2=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV src1=0x80000000, src2=0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- DIVU src1=7, src2=0 → HI=0x00000007, LO=0xFFFFFFFF.
- Control and reset cases:
  - MTHI 0x1234 then MULTU 3×5; flush at cycle 10 → busy drops next cycle, no done, HI stays 0x1234.
  - Repeat without flush → HI=0, LO=15.
  - rst_n low at cycle 20 of a DIV → hi=lo=0, busy=0 immediately.
